// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the memory-access stage: FSM state encoding,
// load/store funct3 codes and byte-lane helpers.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte offset actually used for the access: halves drop bit 0, words
    // (and undefined funct3, treated as words) drop both bits.
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: align_off = a;
            F3_H, F3_HU: align_off = {a[1], 1'b0};
            default:     align_off = 2'b00;
        endcase
    endfunction

    // Byte-enable mask for an access of the given size at the given offset.
    function automatic logic [3:0] be_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: be_mask = 4'b0001 << off;
            F3_H, F3_HU: be_mask = 4'b0011 << off;
            default:     be_mask = 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane the access could target.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            F3_B, F3_BU: store_lanes = {4{sd[7:0]}};
            F3_H, F3_HU: store_lanes = {2{sd[15:0]}};
            default:     store_lanes = sd;
        endcase
    endfunction

    // True when the unaligned address cannot be served by a single access.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: is_misaligned = 1'b0;
            F3_H, F3_HU: is_misaligned = a[0];
            default:     is_misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Ready/acknowledge data-memory bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_formatter.sv
// Load-data formatter: picks the addressed byte/half out of the read word and
// sign- or zero-extends it; undefined funct3 returns the whole word.
module load_formatter
    import riscv_mem_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by extension according to funct3.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data = {24'd0, byte_lane};
            F3_H:    data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data = {16'd0, half_lane};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on the data bus, stalls
// the pipeline while the bus is busy, aborts after TIMEOUT unacknowledged
// cycles and returns formatted load data.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned H/W accesses
// instead of silently aligning them down).
module mem_access_stage
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [31:0]                ALUResIn,
    input  logic [31:0]                store_data,
    input  logic [2:0]                 dm_ctrl,
    input  logic                       dm_write,
    input  logic                       dm_read,
    output logic                       stall_out,
    mem_access_stage_if.master         bus,
    output logic [31:0]                DMDataRdOut,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                       misaligned,
`endif
    output logic                       bus_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic          start;
    logic          trap;
    logic [1:0]    off;
    logic [2:0]    ld_f3;
    logic [1:0]    ld_off;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   ld_data;

    assign start     = (state == IDLE) && valid_in && (dm_read || dm_write);
    assign stall_out = start || (state == WAIT);
    assign off       = align_off(dm_ctrl, ALUResIn[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_misaligned(dm_ctrl, ALUResIn[1:0]);
`else
    assign trap = 1'b0;
`endif

    load_formatter u_fmt (
        .mem_rdata (bus.mem_rdata),
        .addr_lo   (ld_off),
        .funct3    (ld_f3),
        .data      (ld_data)
    );

    // Access FSM with registered bus outputs, timeout counter and result.
    // Without the trap build, off is already aligned down, so unaligned H/W
    // accesses proceed on the containing word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            DMDataRdOut   <= '0;
            bus_err       <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned    <= 1'b0;
`endif
            wait_cnt      <= '0;
            ld_f3         <= '0;
            ld_off        <= '0;
        end else begin
            bus_err <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    DMDataRdOut <= '0;
                    if (start && trap) begin
                        state <= RESP;
`ifdef MEM_MISALIGN_TRAP_EN
                        misaligned <= 1'b1;
`endif
                    end else if (start) begin
                        state         <= WAIT;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= dm_write;
                        bus.mem_addr  <= {ALUResIn[31:2], 2'b00};
                        bus.mem_be    <= dm_write ? be_mask(dm_ctrl, off) : 4'b0000;
                        bus.mem_wdata <= dm_write ? store_lanes(dm_ctrl, store_data) : '0;
                        ld_f3         <= dm_ctrl;
                        ld_off        <= off;
                        wait_cnt      <= '0;
                    end
                end
                WAIT: begin
                    if (bus.mem_ack || wait_cnt == LAST) begin
                        state         <= RESP;
                        DMDataRdOut   <= (bus.mem_ack && !bus.mem_we) ? ld_data : '0;
                        bus_err       <= !bus.mem_ack;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        bus.mem_be    <= '0;
                        wait_cnt      <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    DMDataRdOut <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT = 16).
// Handles both builds of MEM_MISALIGN_TRAP_EN.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] ALUResIn;
    logic [31:0] store_data;
    logic [2:0]  dm_ctrl;
    logic        dm_write;
    logic        dm_read;
    logic        stall_out;
    logic [31:0] DMDataRdOut;
    logic        bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Values observed by the last mem_op call
    int          op_stalls;
    logic [31:0] op_res;
    logic        op_err;
    logic        op_mis;
    logic        op_saw_req;
    logic [31:0] op_addr;
    logic [3:0]  op_be;
    logic [31:0] op_wdata;
    logic        op_we;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .ALUResIn    (ALUResIn),
        .store_data  (store_data),
        .dm_ctrl     (dm_ctrl),
        .dm_write    (dm_write),
        .dm_read     (dm_read),
        .stall_out   (stall_out),
        .bus         (bus),
        .DMDataRdOut (DMDataRdOut),
`ifdef MEM_MISALIGN_TRAP_EN
        .misaligned  (misaligned),
`endif
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        next();
        valid_in = 1'b0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    // Present one instruction (called at posedge+1 with the DUT idle) and
    // hold it until stall_out drops; ack_after = -1 means never acknowledge,
    // otherwise ack arrives after that many unacknowledged WAIT cycles.
    // Returns in the RESP cycle.
    task automatic mem_op(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                          input logic rd, input logic wr, input int ack_after,
                          input logic [31:0] rdata);
        int  waits = 0;
        bit  done  = 0;
        op_stalls  = 0; op_res = '0; op_err = 0; op_mis = 0; op_saw_req = 0;
        op_addr = '0; op_be = '0; op_wdata = '0; op_we = 0;
        valid_in = 1'b1; ALUResIn = a; store_data = sd; dm_ctrl = f3;
        dm_read = rd; dm_write = wr;
        for (int c = 0; c < 64 && !done; c++) begin
            if (bus.mem_req) begin
                op_saw_req = 1; op_addr = bus.mem_addr; op_be = bus.mem_be;
                op_wdata = bus.mem_wdata; op_we = bus.mem_we;
                if (ack_after >= 0 && waits == ack_after) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
                end else begin
                    bus.mem_ack = 1'b0;
                end
                waits++;
            end else begin
                bus.mem_ack = 1'b0;
            end
            #1;
            if (stall_out) begin
                op_stalls++;
                next();
            end else begin
                done   = 1;
                op_res = DMDataRdOut;
                op_err = bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
                op_mis = misaligned;
`endif
            end
        end
        if (!done) check("op_never_completed", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; ALUResIn = '0; store_data = '0;
        dm_ctrl = '0; dm_write = 1'b0; dm_read = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // Reset state
        #12;
        check("rst_mem_req",   32'(bus.mem_req), 32'd0);
        check("rst_mem_addr",  bus.mem_addr, 32'd0);
        check("rst_dmdata",    DMDataRdOut, 32'd0);
        check("rst_bus_err",   32'(bus_err), 32'd0);
        check("rst_stall",     32'(stall_out), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("rst_misaligned", 32'(misaligned), 32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;
        next();

        // LB 0x1003, data 0x80112233, ack in first WAIT cycle
        mem_op(32'h1003, 32'h0, 3'b000, 1, 0, 0, 32'h80112233);
        check("lb_addr",   op_addr, 32'h1000);
        check("lb_be",     32'(op_be), 32'h0);
        check("lb_we",     32'(op_we), 32'd0);
        check("lb_data",   op_res, 32'hFFFFFF80);
        check("lb_stall",  32'(op_stalls), 32'd2);
        idle();
        check("after_lb_data", DMDataRdOut, 32'd0);

        // SH 0x2002 of 0xBEEF, three unacknowledged WAIT cycles
        mem_op(32'h2002, 32'h0000BEEF, 3'b001, 0, 1, 3, 32'h0);
        check("sh_be",     32'(op_be), 32'hC);
        check("sh_wdata",  op_wdata, 32'hBEEFBEEF);
        check("sh_we",     32'(op_we), 32'd1);
        check("sh_addr",   op_addr, 32'h2000);
        check("sh_stall",  32'(op_stalls), 32'd5);
        idle();

        // SB 0x3001 of 0xA5
        mem_op(32'h3001, 32'h123456A5, 3'b000, 0, 1, 0, 32'h0);
        check("sb_be",     32'(op_be), 32'h2);
        check("sb_wdata",  op_wdata, 32'hA5A5A5A5);
        idle();

        // LBU 0x3001, LH 0x100, LHU 0x102
        mem_op(32'h3001, 32'h0, 3'b100, 1, 0, 1, 32'h0000C300);
        check("lbu_data",  op_res, 32'h000000C3);
        idle();
        mem_op(32'h100, 32'h0, 3'b001, 1, 0, 0, 32'h1234ABCD);
        check("lh_data",   op_res, 32'hFFFFABCD);
        idle();
        mem_op(32'h102, 32'h0, 3'b101, 1, 0, 0, 32'h80112233);
        check("lhu_data",  op_res, 32'h00008011);
        idle();

        // Undefined funct3 load behaves as LW
        mem_op(32'h20, 32'h0, 3'b011, 1, 0, 0, 32'hDEADBEEF);
        check("f3x_data",  op_res, 32'hDEADBEEF);
        idle();

        // dm_read and dm_write together: a store, no load data
        mem_op(32'h10, 32'hCAFEF00D, 3'b010, 1, 1, 0, 32'h55555555);
        check("rw_we",     32'(op_we), 32'd1);
        check("rw_be",     32'(op_be), 32'hF);
        check("rw_wdata",  op_wdata, 32'hCAFEF00D);
        check("rw_data",   op_res, 32'd0);
        idle();

        // LW 0x40, never acknowledged: timeout abort
        mem_op(32'h40, 32'h0, 3'b010, 1, 0, -1, 32'h0);
        check("to_stall",  32'(op_stalls), 32'd17);
        check("to_err",    32'(op_err), 32'd1);
        check("to_data",   op_res, 32'd0);
        idle();
        #1;
        check("to_err_pulse", 32'(bus_err), 32'd0);
        check("to_resume",    32'(stall_out), 32'd0);

        // Ack on the timeout cycle wins
        mem_op(32'h44, 32'h0, 3'b010, 1, 0, 15, 32'h12345678);
        check("tack_stall", 32'(op_stalls), 32'd17);
        check("tack_err",   32'(op_err), 32'd0);
        check("tack_data",  op_res, 32'h12345678);
        idle();

        // LW 0x42: trapped with the macro, aligned down without it
        mem_op(32'h42, 32'h0, 3'b010, 1, 0, 0, 32'h11223344);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_req",    32'(op_saw_req), 32'd0);
        check("mis_flag",   32'(op_mis), 32'd1);
        check("mis_stall",  32'(op_stalls), 32'd1);
        check("mis_data",   op_res, 32'd0);
`else
        check("al_req",     32'(op_saw_req), 32'd1);
        check("al_addr",    op_addr, 32'h40);
        check("al_stall",   32'(op_stalls), 32'd2);
        check("al_data",    op_res, 32'h11223344);
`endif
        idle();

        // ADD with valid_in: no stall, no bus activity; stray ack ignored
        valid_in = 1'b1; ALUResIn = 32'h1234; dm_read = 1'b0; dm_write = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        #1;
        check("add_stall", 32'(stall_out), 32'd0);
        next();
        check("add_req",   32'(bus.mem_req), 32'd0);
        check("add_data",  DMDataRdOut, 32'd0);
        idle();

        // Reset during the second WAIT cycle, ack arrives after release
        valid_in = 1'b1; ALUResIn = 32'h80; dm_ctrl = 3'b010; dm_read = 1'b1;
        next();
        check("rw1_req",   32'(bus.mem_req), 32'd1);
        next();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",  32'(bus.mem_req), 32'd0);
        check("arst_addr", bus.mem_addr, 32'd0);
        valid_in = 1'b0; dm_read = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        next();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
        next();
        bus.mem_ack = 1'b0;
        check("late_ack_req",   32'(bus.mem_req), 32'd0);
        check("late_ack_data",  DMDataRdOut, 32'd0);
        check("late_ack_err",   32'(bus_err), 32'd0);
        check("late_ack_stall", 32'(stall_out), 32'd0);

        // Back in IDLE: a fresh load behaves normally
        mem_op(32'h1003, 32'h0, 3'b000, 1, 0, 0, 32'h7F000000);
        check("post_rst_stall", 32'(op_stalls), 32'd2);
        check("post_rst_data",  op_res, 32'h0000007F);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
